// File: rtl/rof_sequencer.sv
// rof_sequencer: walks a synchronous ROM through a filter and writes the
// filtered stream into RAM, then lets the user browse the RAM with two buttons.
// Every output comes straight from a flop.
module rof_sequencer #(
  parameter int N         = 3,
  parameter int ADDR_BITS = 8,
  parameter int NO_INPUT  = 255,
  parameter int LAT       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 rd_up,
  input  logic                 rd_down,
  output logic [ADDR_BITS-1:0] rom_addr,
  output logic                 sample_valid,
  output logic                 filt_clr,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_wr_addr,
  output logic [ADDR_BITS-1:0] rd_addr,
  output logic                 busy,
  output logic                 done
);

  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(NO_INPUT - 1);
  localparam logic [ADDR_BITS-1:0] ONE  = ADDR_BITS'(1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   rom_addr_q, rom_addr_d;
  logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_BITS-1:0]   rd_addr_q, rd_addr_d;
  logic [LAT-1:0]         vld_q, vld_d;
  logic                   sv_q, sv_d;
  logic                   clr_q, clr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   up_q, dn_q;
  logic                   launch, last_wr, up_edge, dn_edge;

  // ram_we is the oldest bit of the valid pipe
  assign last_wr = vld_q[LAT-1] && (wr_addr_q == LAST);
  assign launch  = (state_q == S_IDLE) && start && !abort;
  assign up_edge = rd_up & ~up_q;
  assign dn_edge = rd_down & ~dn_q;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      vld_q      <= '0;
      sv_q       <= 1'b0;
      clr_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      vld_q      <= vld_d;
      sv_q       <= sv_d;
      clr_q      <= clr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      up_q       <= rd_up;
      dn_q       <= rd_down;
    end
  end

  // Next state; abort wins over everything, including start
  always_comb begin
    state_d = state_q;
    if (abort) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_FETCH;
        S_FETCH: if (rom_addr_q == LAST) state_d = S_DRAIN;
        S_DRAIN: if (last_wr) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs
  always_comb begin
    rom_addr_d = rom_addr_q;
    wr_addr_d  = wr_addr_q;
    if (abort || launch) begin
      rom_addr_d = '0;
      wr_addr_d  = '0;
    end else begin
      if (state_q == S_FETCH && rom_addr_q != LAST) rom_addr_d = rom_addr_q + ONE;
      if (vld_q[LAT-1]) wr_addr_d = wr_addr_q + ONE;
    end
    // ROM data for the address issued this cycle is valid next cycle
    sv_d   = (state_q == S_FETCH) && !abort;
    vld_d  = abort ? '0 : ((vld_q << 1) | LAT'(sv_q));
    clr_d  = launch;
    busy_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
    done_d = (state_q == S_DRAIN) && last_wr && !abort;
  end

  // Display address browsing, frozen while a run is in flight
  always_comb begin
    rd_addr_d = rd_addr_q;
    if (!busy_q) begin
      if (up_edge && !dn_edge)      rd_addr_d = rd_addr_q + ONE;
      else if (dn_edge && !up_edge) rd_addr_d = rd_addr_q - ONE;
    end
  end

  // A filter without a window has nothing to clear
  if (N >= 1) begin : g_clr
    assign filt_clr = clr_q;
  end else begin : g_noclr
    assign filt_clr = 1'b0;
  end

  assign rom_addr     = rom_addr_q;
  assign sample_valid = sv_q;
  assign ram_we       = vld_q[LAT-1];
  assign ram_wr_addr  = wr_addr_q;
  assign rd_addr      = rd_addr_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_rof_sequencer.sv
// Bench for rof_sequencer: a default instance plus a NO_INPUT=1/LAT=1 instance.
// Expected RAM write addresses are queued at start and popped on each ram_we.
module tb_rof_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 0, abort0 = 0, up = 0, dn = 0;
  logic start1 = 0, abort1 = 0, up1 = 0, dn1 = 0;

  logic [7:0] ra0, wa0, rd0, ra1, wa1, rd1;
  logic sv0, fc0, we0, bz0, dn0_o, sv1, fc1, we1, bz1, dn1_o;

  int checks = 0;
  int errors = 0;
  int expq[$];
  logic [7:0] exp_rd = 0;

  always #5 clk = ~clk;

  rof_sequencer dut (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .rd_up(up), .rd_down(dn),
    .rom_addr(ra0), .sample_valid(sv0), .filt_clr(fc0), .ram_we(we0),
    .ram_wr_addr(wa0), .rd_addr(rd0), .busy(bz0), .done(dn0_o)
  );

  rof_sequencer #(.N(3), .ADDR_BITS(8), .NO_INPUT(1), .LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .rd_up(up1), .rd_down(dn1),
    .rom_addr(ra1), .sample_valid(sv1), .filt_clr(fc1), .ram_we(we1),
    .ram_wr_addr(wa1), .rd_addr(rd1), .busy(bz1), .done(dn1_o)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({ra0, wa0, rd0, sv0, fc0, we0, bz0, dn0_o} !== '0) begin
      errors++; $display("FAIL reset0 got %h exp 0", {ra0, wa0, rd0, sv0, fc0, we0, bz0, dn0_o});
    end
    checks++;
    if ({ra1, wa1, rd1, sv1, fc1, we1, bz1, dn1_o} !== '0) begin
      errors++; $display("FAIL reset1 got %h exp 0", {ra1, wa1, rd1, sv1, fc1, we1, bz1, dn1_o});
    end
    step(); step();
    rst = 0;
    step();
  endtask

  // One full run on the selected instance with cycle-exact window checks
  task automatic test_run(input bit sel);
    int n, lat;
    logic fc, sv, we, dn_, bz;
    logic [7:0] wa;
    n   = sel ? 1 : 255;
    lat = sel ? 1 : 2;
    for (int i = 0; i < n; i++) expq.push_back(i);
    if (sel) start1 = 1; else start0 = 1;
    step();
    start0 = 0; start1 = 0;
    for (int c = 0; c <= n + lat + 3; c++) begin
      fc = sel ? fc1 : fc0;   sv = sel ? sv1 : sv0;  we = sel ? we1 : we0;
      dn_ = sel ? dn1_o : dn0_o; bz = sel ? bz1 : bz0; wa = sel ? wa1 : wa0;
      checks++;
      if (fc !== (c == 0)) begin errors++; $display("FAIL run%0d.filt_clr c=%0d got %b", sel, c, fc); end
      checks++;
      if (sv !== (c >= 1 && c <= n)) begin errors++; $display("FAIL run%0d.sample_valid c=%0d got %b", sel, c, sv); end
      checks++;
      if (we !== (c >= 1 + lat && c <= n + lat)) begin errors++; $display("FAIL run%0d.ram_we c=%0d got %b", sel, c, we); end
      checks++;
      if (dn_ !== (c == n + lat + 1)) begin errors++; $display("FAIL run%0d.done c=%0d got %b", sel, c, dn_); end
      checks++;
      if (bz !== (c <= n + lat)) begin errors++; $display("FAIL run%0d.busy c=%0d got %b", sel, c, bz); end
      if (we === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin errors++; $display("FAIL run%0d.extra_write c=%0d addr %0d", sel, c, wa); end
        else begin
          int e;
          e = expq.pop_front();
          if (wa !== 8'(e)) begin errors++; $display("FAIL run%0d.wr_addr c=%0d got %0d exp %0d", sel, c, wa, e); end
        end
      end
      step();
    end
    checks++;
    if (expq.size() != 0) begin errors++; $display("FAIL run%0d.missing_writes left %0d exp 0", sel, expq.size()); end
    expq.delete();
  endtask

  // Start held high across DONE relaunches the short instance every 5 cycles
  task automatic test_back_to_back();
    expq.push_back(0); expq.push_back(0);
    start1 = 1;
    step();
    for (int c = 0; c <= 9; c++) begin
      checks++;
      if (fc1 !== (c == 0 || c == 5)) begin errors++; $display("FAIL b2b.filt_clr c=%0d got %b", c, fc1); end
      checks++;
      if (dn1_o !== (c == 3 || c == 8)) begin errors++; $display("FAIL b2b.done c=%0d got %b", c, dn1_o); end
      checks++;
      if (we1 !== (c == 2 || c == 7)) begin errors++; $display("FAIL b2b.ram_we c=%0d got %b", c, we1); end
      if (we1 === 1'b1 && expq.size() != 0) begin
        int e;
        e = expq.pop_front();
        checks++;
        if (wa1 !== 8'(e)) begin errors++; $display("FAIL b2b.wr_addr c=%0d got %0d exp %0d", c, wa1, e); end
      end
      if (c == 9) start1 = 0;
      step();
    end
    checks++;
    if (expq.size() != 0 || bz1 !== 1'b0) begin
      errors++; $display("FAIL b2b.end left %0d busy %b exp 0 0", expq.size(), bz1);
    end
    expq.delete();
  endtask

  task automatic test_abort();
    int n_done, n_we;
    for (int i = 0; i < 255; i++) expq.push_back(i);
    start0 = 1;
    step();
    start0 = 0;
    for (int c = 0; c < 50; c++) begin
      if (we0 === 1'b1 && expq.size() != 0) begin
        int e;
        e = expq.pop_front();
        checks++;
        if (wa0 !== 8'(e)) begin errors++; $display("FAIL abort.wr_addr c=%0d got %0d exp %0d", c, wa0, e); end
      end
      step();
    end
    abort0 = 1; start0 = 1;
    step();
    abort0 = 0; start0 = 0;
    checks++;
    if ({bz0, we0, sv0, dn0_o} !== 4'b0) begin
      errors++; $display("FAIL abort.outputs got %b exp 0000", {bz0, we0, sv0, dn0_o});
    end
    expq.delete();
    n_done = 0; n_we = 0;
    for (int c = 0; c < 300; c++) begin
      if (dn0_o === 1'b1) n_done++;
      if (we0 === 1'b1 || bz0 === 1'b1) n_we++;
      step();
    end
    checks++;
    if (n_done != 0) begin errors++; $display("FAIL abort.done_seen got %0d exp 0", n_done); end
    checks++;
    if (n_we != 0) begin errors++; $display("FAIL abort.activity_seen got %0d exp 0", n_we); end
    test_run(0);
  endtask

  task automatic pulse_rd(input bit u, input bit d);
    up = u; dn = d;
    step();
    up = 0; dn = 0;
    step();
  endtask

  task automatic test_rd_addr();
    for (int i = 0; i < 3; i++) pulse_rd(0, 1);
    exp_rd = 8'd253;
    checks++;
    if (rd0 !== exp_rd) begin errors++; $display("FAIL rd.down3 got %0d exp %0d", rd0, exp_rd); end
    pulse_rd(1, 0);
    exp_rd = 8'd254;
    checks++;
    if (rd0 !== exp_rd) begin errors++; $display("FAIL rd.up1 got %0d exp %0d", rd0, exp_rd); end
    pulse_rd(1, 1);
    checks++;
    if (rd0 !== exp_rd) begin errors++; $display("FAIL rd.both got %0d exp %0d", rd0, exp_rd); end
  endtask

  task automatic test_rd_busy();
    start0 = 1;
    step();
    start0 = 0;
    for (int c = 0; c < 265; c++) begin
      up = (c == 20 || c == 40 || c >= 250);
      step();
    end
    checks++;
    if (rd0 !== exp_rd) begin errors++; $display("FAIL rd_busy.held got %0d exp %0d", rd0, exp_rd); end
    up = 0;
    step();
    pulse_rd(1, 0);
    exp_rd = exp_rd + 8'd1;
    checks++;
    if (rd0 !== exp_rd) begin errors++; $display("FAIL rd_busy.idle_up got %0d exp %0d", rd0, exp_rd); end
  endtask

  task automatic test_rst_mid();
    int n_done;
    start0 = 1;
    step();
    start0 = 0;
    for (int c = 0; c < 256; c++) step();
    checks++;
    if (we0 !== 1'b1 || bz0 !== 1'b1) begin errors++; $display("FAIL rst_mid.in_drain we %b busy %b exp 1 1", we0, bz0); end
    rst = 1;
    #2;
    checks++;
    if ({ra0, wa0, rd0, sv0, fc0, we0, bz0, dn0_o} !== '0) begin
      errors++; $display("FAIL rst_mid.async got %h exp 0", {ra0, wa0, rd0, sv0, fc0, we0, bz0, dn0_o});
    end
    rst = 0;
    exp_rd = 0;
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (dn0_o === 1'b1 || bz0 === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 0) begin errors++; $display("FAIL rst_mid.resumed got %0d exp 0", n_done); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_run(0);
    test_run(1);
    test_back_to_back();
    test_rd_addr();
    test_abort();
    test_rd_busy();
    test_rst_mid();
    test_run(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rof_sequencer.md
ROF_SEQUENCER -- requirements
Module: rof_sequencer

Interface
REQ-001 SHALL have parameter N, default 3, filter window length.
REQ-002 SHALL have parameter ADDR_BITS, default 8, ROM/RAM address width.
REQ-003 SHALL have parameter NO_INPUT, default 255, samples per run (1..2^ADDR_BITS-1).
REQ-004 SHALL have parameter LAT, default 2, filter latency from sample_valid to filtered output valid (>=1).
REQ-005 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports: start  in  1  level; begin run when idle.
REQ-008 SHALL have ports: abort  in  1  level; cancel run.
REQ-009 SHALL have ports: rd_up, rd_down  in  1 each  debounced buttons, level.
REQ-010 SHALL have ports: rom_addr  out  ADDR_BITS  ROM read address (1-cycle synchronous ROM).
REQ-011 SHALL have ports: sample_valid  out  1  ROM data valid to filter this cycle.
REQ-012 SHALL have ports: filt_clr  out  1  one-cycle filter window clear.
REQ-013 SHALL have ports: ram_we  out  1  RAM write enable for filter output.
REQ-014 SHALL have ports: ram_wr_addr  out  ADDR_BITS  RAM write address.
REQ-015 SHALL have ports: rd_addr  out  ADDR_BITS  RAM readback address for display.
REQ-016 SHALL have ports: busy  out  1  run in progress; done  out  1  one-cycle run complete.

Function
REQ-017 SHALL implement FSM IDLE, FETCH, DRAIN, DONE; all outputs registered.
REQ-018 IDLE: start=1 at edge k -> FETCH, rom_addr=0, busy=1, filt_clr=1 during cycle k..k+1 only.
REQ-019 FETCH: rom_addr increments by 1 each edge; address 0..NO_INPUT-1 each issued exactly once.
REQ-020 sample_valid SHALL be high the cycle after each FETCH address issue (cycles k+1..k+NO_INPUT).
REQ-021 After address NO_INPUT-1 issued -> DRAIN; rom_addr holds NO_INPUT-1.
REQ-022 ram_we SHALL equal sample_valid delayed exactly LAT cycles via a LAT-deep valid shift register.
REQ-023 ram_wr_addr SHALL be 0 on first write of a run, increment by 1 after each write, never wrap within a run.
REQ-024 DRAIN: after the NO_INPUT-th write -> DONE; DONE asserts done one cycle, busy=0, -> IDLE.
REQ-025 start while not IDLE SHALL be ignored; start held high in IDLE after DONE SHALL begin a new run.
REQ-026 abort=1 in any state SHALL -> IDLE next edge, clear valid shift register, sample_valid=0, ram_we=0, busy=0, no done; abort has priority over start.
REQ-027 rd_addr SHALL edge-detect rd_up/rd_down (rising edge, registered previous value); up edge +1, down edge -1, modulo 2^ADDR_BITS.
REQ-028 Simultaneous up and down edges SHALL leave rd_addr unchanged.
REQ-029 rd_addr SHALL update only when busy=0; edges while busy discarded; abort does not change rd_addr.

Reset
REQ-030 rst=1 SHALL immediately force IDLE; rom_addr, ram_wr_addr, rd_addr = 0; sample_valid, filt_clr, ram_we, busy, done = 0; valid shift register and edge-detect registers cleared.
REQ-031 rst asserted mid-run SHALL abandon run without done; operation resumes only on a fresh start after rst=0.

Verification
REQ-032 Defaults, start pulse at edge 10 -> filt_clr high cycle 10, sample_valid high cycles 11..265, ram_we high 13..267, ram_wr_addr 0..254, done high cycle 268 only.
REQ-033 abort at cycle 50 of a run -> busy=0, ram_we=0 from next edge, done never asserted; subsequent start gives full 255-write run from ram_wr_addr 0.
REQ-034 rd_addr=0, three rd_down edges while idle -> 253; one rd_up edge -> 254; simultaneous up+down -> 254.
REQ-035 rd_up edges during busy -> rd_addr unchanged; rd_up held high across run end -> no spurious increment.
REQ-036 rst pulse mid-DRAIN -> all outputs zero asynchronously before next clk edge; no done.
REQ-037 NO_INPUT=1, LAT=1 -> exactly one sample_valid, one ram_we at address 0, done one cycle later.
